bp_reaction_sequencer: RTL
==========================

# bp_reaction_sequencer

Round sequencer for the LED reaction-timer game. It runs one round at a time. First it waits a pseudo-random delay. It then lights one randomly chosen LED lane and counts milliseconds until the player flips the matching switch. It also tracks the best valid time and detects false starts. It sits between the debounced button and switch inputs and the 7-segment and LED output logic, and owns all sequencing of the timer datapath.

## Interface
- CLK_PER_MS, 25000: clock cycles per millisecond tick (25 MHz clock).
- MIN_DELAY_MS, 1000: fixed part of the pre-GO delay, in ms.
- DELAY_BITS, 10: width of the random delay extension (0..2^DELAY_BITS-1 ms). Must be ≤ 13.
- TIMEOUT_MS, 9999: maximum reaction count. It saturates at this value.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse, debounced upstream. Begins a round.
- sw  in  8  player switches, lane i = sw[i].
- led  out  8  lit lane, one-hot in GO, all ones in FOUL, zero otherwise.
- cur_ms  out  16  current or last reaction time, binary ms.
- best_ms  out  16  best valid time since reset. 16'hFFFF means no valid result yet.
- state  out  3  IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4.
- foul  out  1  high while in FOUL.
- timeout  out  1  set when the last round saturated. Cleared on the next start.

## Operation
- sw is registered once into sw_q. A "change" means sw_q differs from the snapshot. The snapshot is sw_q captured when start is accepted.
- The LFSR is a 16-bit Galois register with taps x^16+x^14+x^13+x^11+1. It is seeded 16'hACE1 on reset and advances every cycle.
- ms tick prescaler:
  - It restarts at 0 on entry to WAIT and on entry to GO.
  - A tick is asserted on the cycle the count equals CLK_PER_MS-1. The count then wraps to 0.
- IDLE:
  - led=0.
  - start → WAIT. On that cycle, lane=lfsr[2:0] and delay=MIN_DELAY_MS+lfsr[3+:DELAY_BITS] are latched, and timeout is cleared.
- WAIT:
  - delay decrements on each tick. When the tick that brings delay to 0 occurs → GO, with cur_ms=0 and led[lane]=1.
  - Any change → FOUL.
- GO:
  - cur_ms increments on each tick.
  - A change on bit lane only → DONE, with cur_ms holding its value before any same-cycle tick.
  - A change on any other bit → FOUL. This has priority over a same-cycle lane change.
  - A tick that makes cur_ms equal TIMEOUT_MS → DONE with timeout=1.
  - A lane change on the same cycle as the timeout tick wins: valid result, timeout=0, cur_ms at its pre-tick value.
- DONE:
  - led=0, cur_ms held.
  - On entry with timeout=0 and cur_ms<best_ms, best_ms←cur_ms. A timeout result never updates best_ms.
  - start → WAIT (new round).
- FOUL:
  - led=8'hFF, cur_ms held, best_ms unchanged.
  - start → WAIT.
- start is ignored in WAIT and GO.

## Timing
- Reset values on the first rising edge with rst=0:
  - state=IDLE, led=0, cur_ms=0, best_ms=16'hFFFF, foul=0, timeout=0.
  - Prescaler 0, lfsr=16'hACE1, snapshot=0.
- rst low at any point, including mid-round, forces all reset values at the next edge.
- Outputs are registered. state, led and foul change on the same edge.
- start accepted at edge N → state=WAIT after edge N.
- GO entered exactly (delay)·CLK_PER_MS cycles after WAIT entry.
- A switch edge arriving before edge N is registered into sw_q at N. The resulting transition happens at edge N+1, giving 2-cycle response latency.
- cur_ms update latency is 0 cycles after the tick edge. Width rules:
  - 16-bit unsigned.
  - No wrap, because it saturates at TIMEOUT_MS.
  - The delay counter is 14 bits.

## Configuration
- BP_FOUL_DETECT_EN:
  - Defined: behaviour as above.
  - Undefined:
    - Changes during WAIT are ignored.
    - Non-lane changes during GO are ignored.
    - FOUL is unreachable and foul is tied 0.
    - The snapshot is re-captured on every cycle of WAIT and on every cycle of GO where no lane change occurs, so that only a lane change from current position ends the round.

## Test plan
Bench parameters: CLK_PER_MS=4, MIN_DELAY_MS=2, DELAY_BITS=2, TIMEOUT_MS=20.
- Reset, then one start pulse:
  - Required: reset values on all outputs, then state=1.
  - After (2+lfsr[4:3])·4 cycles: state=2 and led = one-hot of lfsr[2:0], both computed by the reference LFSR model.
- Toggle sw[lane] after 7 ticks in GO:
  - state=3, cur_ms=7, best_ms=7.
  - Next rounds at 5 then 9: best_ms=5, then stays 5.
- Toggle sw[0] while in WAIT: state=4, foul=1, led=8'hFF, best_ms unchanged. A following start → state=1, foul=0.
- No switch activity in GO: cur_ms=20, timeout=1, state=3, best_ms unchanged. The next start clears timeout.
- Toggle the lane bit and a non-lane bit on the same cycle: state=4. Drive rst=0 mid-GO: next edge gives state=0, led=0, cur_ms=0, best_ms=16'hFFFF.
- Build with BP_FOUL_DETECT_EN undefined:
  - Toggles on other bits during WAIT and GO are ignored.
  - A lane toggle still ends in DONE with the correct cur_ms.
  - foul stays 0 throughout.

Source files
------------

// File: rtl/bp_reaction_sequencer.sv
// Round sequencer for the LED reaction-timer game: random pre-GO delay, lane select, ms counting, best time.
// Optional macro BP_FOUL_DETECT_EN enables false-start (FOUL) detection; without it stray switch moves are ignored.
module bp_reaction_sequencer #(
   parameter int CLK_PER_MS   = 25000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int DELAY_BITS   = 10,
   parameter int TIMEOUT_MS   = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   output logic [15:0] cur_ms,
   output logic [15:0] best_ms,
   output logic [2:0]  state,
   output logic        foul,
   output logic        timeout
);

   localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_GO   = 3'd2,
      S_DONE = 3'd3,
      S_FOUL = 3'd4
   } state_t;

   state_t        st;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [PW-1:0] presc;
   logic          tick;
   logic [7:0]    sw_q;
   logic [7:0]    snap;
   logic [7:0]    diff;
   logic [7:0]    lane_mask;
   logic [2:0]    lane;
   logic [13:0]   delay;
   logic          lane_hit;
   logic          wait_foul;
   logic          go_foul;
   logic          track;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign tick      = (presc == PW'(CLK_PER_MS - 1));
   assign diff      = sw_q ^ snap;
   assign lane_mask = 8'b1 << lane;
   assign lane_hit  = |(diff & lane_mask);

`ifdef BP_FOUL_DETECT_EN
   assign wait_foul = |diff;
   assign go_foul   = |(diff & ~lane_mask);
   assign track     = 1'b0;
`else
   // Snapshot follows the switches so only a fresh lane move ends the round.
   assign wait_foul = 1'b0;
   assign go_foul   = 1'b0;
   assign track     = 1'b1;
`endif

   assign state = st;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st      <= S_IDLE;
         lfsr    <= 16'hACE1;
         presc   <= '0;
         sw_q    <= '0;
         snap    <= '0;
         lane    <= '0;
         delay   <= '0;
         led     <= '0;
         cur_ms  <= '0;
         best_ms <= 16'hFFFF;
         foul    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         lfsr  <= lfsr_next;
         sw_q  <= sw;
         presc <= tick ? '0 : presc + 1'b1;
         case (st)
            S_IDLE, S_DONE, S_FOUL: begin
               if (start) begin
                  st      <= S_WAIT;
                  led     <= '0;
                  foul    <= 1'b0;
                  timeout <= 1'b0;
                  lane    <= lfsr[2:0];
                  delay   <= 14'(MIN_DELAY_MS) + 14'(lfsr[3 +: DELAY_BITS]);
                  snap    <= sw_q;
                  presc   <= '0;
               end
            end
            S_WAIT: begin
               if (wait_foul) begin
                  st   <= S_FOUL;
                  led  <= 8'hFF;
                  foul <= 1'b1;
               end else begin
                  if (track) snap <= sw_q;
                  if (tick) begin
                     delay <= delay - 14'd1;
                     if (delay <= 14'd1) begin
                        st     <= S_GO;
                        cur_ms <= '0;
                        led    <= lane_mask;
                        presc  <= '0;
                     end
                  end
               end
            end
            S_GO: begin
               if (go_foul) begin
                  st   <= S_FOUL;
                  led  <= 8'hFF;
                  foul <= 1'b1;
               end else if (lane_hit) begin
                  // Valid result keeps the pre-tick count, even against a same-cycle timeout.
                  st  <= S_DONE;
                  led <= '0;
                  if (cur_ms < best_ms) best_ms <= cur_ms;
               end else begin
                  if (track) snap <= sw_q;
                  if (tick) begin
                     cur_ms <= cur_ms + 16'd1;
                     if (cur_ms + 16'd1 >= 16'(TIMEOUT_MS)) begin
                        st      <= S_DONE;
                        led     <= '0;
                        timeout <= 1'b1;
                     end
                  end
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
